draw_scheduler: RTL and testbench

Queued drawing controller for the VGA visuals path: accepts rectangle draw commands (boxes, connection lines) from display sequencers, buffers them in a small FIFO, and walks each rectangle pixel by pixel onto the single VGA plot port. It keeps shapes from contending for the plot port and adds screen clipping and plot backpressure. It sits between the transaction/verification display sequencers and the VGA adapter.

---
 rtl/draw_pkg.sv | 40 ++++
 rtl/draw_cmd_fifo.sv | 52 +++++
 rtl/draw_scheduler.sv | 144 ++++++++++++++
 tb/tb_draw_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the queued rectangle drawing path.
package draw_pkg;

  localparam int X_W  = 10;
  localparam int Y_W  = 9;
  localparam int S_W  = 6;
  localparam int C_W  = 3;
  localparam int XE_W = X_W + 1;
  localparam int YE_W = Y_W + 1;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [S_W-1:0] w_m1;
    logic [S_W-1:0] h_m1;
    logic [C_W-1:0] colour;
    logic           last;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  // Extra msb keeps base + offset from wrapping past the screen edge.
  function automatic logic [XE_W-1:0] raster_x(input logic [X_W-1:0] base,
                                               input logic [S_W-1:0] off);
    return {1'b0, base} + XE_W'(off);
  endfunction

  function automatic logic [YE_W-1:0] raster_y(input logic [Y_W-1:0] base,
                                               input logic [S_W-1:0] off);
    return {1'b0, base} + YE_W'(off);
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous command FIFO of draw_cmd_t; push is ignored when full, pop when empty.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  draw_cmd_t        wdata,
  input  logic             pop,
  output draw_cmd_t        rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  draw_cmd_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Queues rectangle commands and rasterises them row-major onto one plot port.
//   state | meaning
//   IDLE  | wait for a queued command, pop it into the working registers
//   DRAW  | walk the rectangle; clipped pixels take one cycle, visible ones wait for plot_ready
//   DONE  | one-cycle job_done pulse after a cmd_last shape
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [S_W-1:0] cmd_w_m1,
  input  logic [S_W-1:0] cmd_h_m1,
  input  logic [C_W-1:0] cmd_colour,
  input  logic           cmd_last,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y,
  output logic [C_W-1:0] plot_colour,
  output logic           plot,
  input  logic           plot_ready,
  output logic           busy,
  output logic           job_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  draw_cmd_t        fifo_wdata, fifo_head;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  state_t           state_q, state_d;
  draw_cmd_t        cur_q, cur_d;
  logic [S_W-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic             plot_q, plot_d;
  logic             job_done_q, job_done_d;
  logic [X_W-1:0]   plot_x_q, plot_x_d;
  logic [Y_W-1:0]   plot_y_q, plot_y_d;
  logic [C_W-1:0]   plot_colour_q, plot_colour_d;
  logic [XE_W-1:0]  px_next;
  logic [YE_W-1:0]  py_next;
  logic             clip_next;

  assign fifo_wdata = '{x: cmd_x, y: cmd_y, w_m1: cmd_w_m1, h_m1: cmd_h_m1,
                        colour: cmd_colour, last: cmd_last};

  draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);
  assign plot        = plot_q;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = plot_colour_q;
  assign job_done    = job_done_q;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          ox_d     = '0;
          oy_d     = '0;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        // plot_q is only high in DRAW on a visible pixel, so it doubles as "must wait for ready".
        if (!plot_q || plot_ready) begin
          if (ox_q == cur_q.w_m1) begin
            ox_d = '0;
            if (oy_q == cur_q.h_m1) begin
              oy_d    = '0;
              state_d = cur_q.last ? DONE : IDLE;
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next pixel position.
    px_next       = raster_x(cur_d.x, ox_d);
    py_next       = raster_y(cur_d.y, oy_d);
    clip_next     = (px_next >= XE_W'(SCREEN_W)) || (py_next >= YE_W'(SCREEN_H));
    plot_d        = (state_d == DRAW) && !clip_next;
    plot_x_d      = plot_d ? px_next[X_W-1:0] : plot_x_q;
    plot_y_d      = plot_d ? py_next[Y_W-1:0] : plot_y_q;
    plot_colour_d = plot_d ? cur_d.colour : plot_colour_q;
    job_done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      plot_q        <= 1'b0;
      job_done_q    <= 1'b0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      plot_q        <= plot_d;
      job_done_q    <= job_done_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected pixels are queued as commands are sent.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_x;
  logic [8:0] cmd_y;
  logic [5:0] cmd_w_m1;
  logic [5:0] cmd_h_m1;
  logic [2:0] cmd_colour;
  logic       cmd_last;
  logic [9:0] plot_x;
  logic [8:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot;
  logic       plot_ready;
  logic       busy;
  logic       job_done;

  int passed = 0;
  int total  = 0;
  int acc_cnt = 0;
  int job_cnt = 0;
  logic        pr_toggle = 1'b0;
  logic [21:0] exp_q[$];
  logic [21:0] exp_pix;
  logic        stall_q = 1'b0;
  logic [22:0] stall_snap;

  draw_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w_m1    (cmd_w_m1),
    .cmd_h_m1    (cmd_h_m1),
    .cmd_colour  (cmd_colour),
    .cmd_last    (cmd_last),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot        (plot),
    .plot_ready  (plot_ready),
    .busy        (busy),
    .job_done    (job_done)
  );

  always #5 clk = ~clk;

  initial begin
    plot_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pr_toggle) plot_ready = ~plot_ready;
      else plot_ready = 1'b1;
    end
  end

  // Scoreboard: every accepted pixel must be the next expected one; stalled outputs must hold.
  always @(negedge clk) begin
    if (plot === 1'b1 && plot_ready === 1'b1) begin
      acc_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d, required no plot",
                 plot_x, plot_y, plot_colour);
      end else begin
        exp_pix = exp_q.pop_front();
        if ({plot_x, plot_y, plot_colour} !== exp_pix)
          $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   plot_x, plot_y, plot_colour, exp_pix[21:12], exp_pix[11:3], exp_pix[2:0]);
        else passed++;
      end
    end
    if (stall_q) begin
      total++;
      if ({plot, plot_x, plot_y, plot_colour} !== stall_snap)
        $display("FAIL stall_hold: got %h, required %h",
                 {plot, plot_x, plot_y, plot_colour}, stall_snap);
      else passed++;
    end
    stall_q    = (plot === 1'b1 && plot_ready === 1'b0);
    stall_snap = {plot, plot_x, plot_y, plot_colour};
    if (job_done === 1'b1) job_cnt++;
  end

  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input logic [2:0] col, input logic last);
    bit got;
    for (int j = 0; j <= h; j++)
      for (int i = 0; i <= w; i++)
        if (x + i < 640 && y + j < 480)
          exp_q.push_back({10'(x + i), 9'(y + j), col});
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_x      = 10'(x);
    cmd_y      = 9'(y);
    cmd_w_m1   = 6'(w);
    cmd_h_m1   = 6'(h);
    cmd_colour = col;
    cmd_last   = last;
    got = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      $display("FAIL cmd_handshake_timeout: got cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && plot === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) $display("FAIL idle_timeout: got busy=%b pending=%0d, required busy=0 pending=0",
                      busy, exp_q.size());
    else passed++;
  endtask

  // Measurement only: cycles until plot rises, then length of the plot run.
  task automatic get_run(output int waited, output int len);
    waited = 0;
    len    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (plot !== 1'b1 && waited < 400);
    if (plot !== 1'b1) return;
    len = 1;
    while (len < 3000) begin
      @(negedge clk);
      if (plot !== 1'b1) break;
      len++;
    end
  endtask

  task automatic test_reset;
    int acc0;
    reset      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_x      = 10'd5;
    cmd_y      = 9'd5;
    cmd_w_m1   = 6'd1;
    cmd_h_m1   = 6'd1;
    cmd_colour = 3'd7;
    cmd_last   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({plot, job_done, busy, cmd_ready} !== 4'b0001)
      $display("FAIL reset_ctrl: got plot/job_done/busy/cmd_ready=%b, required 0001",
               {plot, job_done, busy, cmd_ready});
    else passed++;
    total++;
    if ({plot_x, plot_y, plot_colour} !== 22'd0)
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d, required 0 0 0",
               plot_x, plot_y, plot_colour);
    else passed++;
    acc0 = acc_cnt;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || acc_cnt != acc0 || job_cnt != 0)
      $display("FAIL reset_cmd_ignored: got busy=%b plots=%0d jobs=%0d, required 0 0 0",
               busy, acc_cnt - acc0, job_cnt);
    else passed++;
  endtask

  task automatic test_single_box;
    int w, l;
    send_cmd(100, 50, 31, 31, 3'b101, 1'b1);
    get_run(w, l);
    total++;
    if (w != 2) $display("FAIL first_plot_latency: got %0d, required 2", w);
    else passed++;
    total++;
    if (l != 1024) $display("FAIL box_run_len: got %0d, required 1024", l);
    else passed++;
    total++;
    if (job_done !== 1'b1) $display("FAIL box_job_done: got %b, required 1", job_done);
    else passed++;
    @(negedge clk);
    total++;
    if (job_done !== 1'b0 || busy !== 1'b0 || job_cnt != 1)
      $display("FAIL box_after: got job_done=%b busy=%b jobs=%0d, required 0 0 1",
               job_done, busy, job_cnt);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL box_pending: got %0d, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back;
    int w1, l1, w2, l2, j0;
    logic jd1, jd2;
    j0 = job_cnt;
    fork
      begin
        send_cmd(200, 100, 31, 1, 3'd2, 1'b0);
        send_cmd(232, 84, 31, 31, 3'd4, 1'b1);
      end
      begin
        get_run(w1, l1);
        jd1 = job_done;
        get_run(w2, l2);
        jd2 = job_done;
      end
    join
    total++;
    if (l1 != 64 || jd1 !== 1'b0)
      $display("FAIL line_run: got len=%0d job_done=%b, required 64 0", l1, jd1);
    else passed++;
    total++;
    if (w2 != 1) $display("FAIL b2b_gap: got %0d, required 1", w2);
    else passed++;
    total++;
    if (l2 != 1024 || jd2 !== 1'b1)
      $display("FAIL b2b_box_run: got len=%0d job_done=%b, required 1024 1", l2, jd2);
    else passed++;
    wait_idle(50);
    total++;
    if (job_cnt != j0 + 1) $display("FAIL b2b_jobs: got %0d, required 1", job_cnt - j0);
    else passed++;
  endtask

  task automatic test_clip;
    int k, plots;
    k = 0;
    plots = 0;
    send_cmd(630, 475, 15, 7, 3'd7, 1'b1);
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (plot === 1'b1) plots++;
      if (job_done === 1'b1) break;
    end
    total++;
    if (k != 130) $display("FAIL clip_cycles: got job_done at %0d, required 130", k);
    else passed++;
    total++;
    if (plots != 50) $display("FAIL clip_plots: got %0d, required 50", plots);
    else passed++;
    wait_idle(20);
  endtask

  task automatic test_backpressure;
    int a0;
    a0 = acc_cnt;
    pr_toggle = 1'b1;
    send_cmd(10, 20, 3, 3, 3'd1, 1'b1);
    wait_idle(300);
    pr_toggle = 1'b0;
    total++;
    if (acc_cnt - a0 != 16) $display("FAIL bp_accepted: got %0d, required 16", acc_cnt - a0);
    else passed++;
  endtask

  task automatic test_fifo_full;
    int j0;
    j0 = job_cnt;
    send_cmd(300, 200, 7, 7, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) send_cmd(10 * i, 300, 3, 1, 3'(i + 1), 1'b0);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL fifo_full: got cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
    else passed++;
    send_cmd(50, 310, 3, 1, 3'd6, 1'b1);
    wait_idle(500);
    total++;
    if (job_cnt != j0 + 1) $display("FAIL fifo_jobs: got %0d, required 1", job_cnt - j0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int base, j0;
    send_cmd(0, 0, 31, 31, 3'd6, 1'b1);
    send_cmd(400, 300, 3, 3, 3'd2, 1'b1);
    send_cmd(420, 300, 3, 3, 3'd5, 1'b1);
    base = acc_cnt - 4;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (acc_cnt >= base + 10) break;
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    j0 = job_cnt;
    @(negedge clk);
    total++;
    if ({plot, busy, job_done, cmd_ready} !== 4'b0001)
      $display("FAIL mid_reset: got plot/busy/job_done/cmd_ready=%b, required 0001",
               {plot, busy, job_done, cmd_ready});
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || job_cnt != j0)
      $display("FAIL mid_reset_quiet: got busy=%b jobs=%0d, required 0 0", busy, job_cnt - j0);
    else passed++;
    send_cmd(50, 60, 3, 3, 3'd3, 1'b1);
    wait_idle(100);
    total++;
    if (job_cnt != j0 + 1) $display("FAIL mid_reset_fresh: got %0d jobs, required 1", job_cnt - j0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_box();
    test_back_to_back();
    test_clip();
    test_backpressure();
    test_fifo_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
